// File: rtl/iiitb_clock_setctl.sv
// rtl/iiitb_clock_setctl.sv - button-driven time/alarm setting controller for the 10 Hz clock core
// Optional snooze (btn_up in IDLE while alarming) is built only when IIITB_SNOOZE_EN is defined.
module iiitb_clock_setctl #(
    parameter int LD_HOLD     = 20,
    parameter int TIMEOUT_CYC = 600,
    parameter int SNOOZE_MIN  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_set,
    input  logic       alarm,
    input  logic [1:0] cur_h1,
    input  logic [3:0] cur_h0,
    input  logic [3:0] cur_m1,
    input  logic [3:0] cur_m0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       STOP_al,
    output logic       edit_active,
    output logic [1:0] edit_field,
    output logic       tgt_alarm,
    output logic       busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SEL      = 3'd1;
    localparam logic [2:0] S_EDIT_HR  = 3'd2;
    localparam logic [2:0] S_EDIT_MIN = 3'd3;
    localparam logic [2:0] S_LOAD     = 3'd4;

    localparam logic [1:0] K_TIME   = 2'd0;
    localparam logic [1:0] K_ALARM  = 2'd1;
    localparam logic [1:0] K_STOP   = 2'd2;
`ifdef IIITB_SNOOZE_EN
    localparam logic [1:0] K_SNOOZE = 2'd3;
`endif

    localparam int LW = $clog2(LD_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    state;
    logic [1:0]    kind;
    logic [4:0]    work_hr;
    logic [5:0]    work_min;
    logic [4:0]    al_hr;
    logic [5:0]    al_min;
    logic [LW-1:0] ld_cnt;
    logic [TW-1:0] to_cnt;

    logic [4:0] cur_hr;
    logic [5:0] cur_min;
    logic [4:0] hr_next;
    logic [5:0] min_next;
    logic [1:0] hr_t;
    logic [3:0] hr_u;
    logic [2:0] mn_t;
    logic [3:0] mn_u;
    logic       any_btn;
    logic       in_edit;
    logic       timed_out;
    logic       strobe_on;

    always_comb begin
        cur_hr   = {3'b000, cur_h1} * 5'd10 + {1'b0, cur_h0};
        cur_min  = {2'b00, cur_m1} * 6'd10 + {2'b00, cur_m0};
        hr_next  = (work_hr == 5'd23) ? 5'd0 : work_hr + 5'd1;
        min_next = (work_min == 6'd59) ? 6'd0 : work_min + 6'd1;

        if (work_hr >= 5'd20)      hr_t = 2'd2;
        else if (work_hr >= 5'd10) hr_t = 2'd1;
        else                       hr_t = 2'd0;
        hr_u = 4'(work_hr - {3'b000, hr_t} * 5'd10);

        if (work_min >= 6'd50)      mn_t = 3'd5;
        else if (work_min >= 6'd40) mn_t = 3'd4;
        else if (work_min >= 6'd30) mn_t = 3'd3;
        else if (work_min >= 6'd20) mn_t = 3'd2;
        else if (work_min >= 6'd10) mn_t = 3'd1;
        else                        mn_t = 3'd0;
        mn_u = 4'(work_min - {3'b000, mn_t} * 6'd10);
    end

`ifdef IIITB_SNOOZE_EN
    logic [6:0] sn_sum;
    logic [4:0] sn_hr;
    logic [5:0] sn_min;

    always_comb begin
        sn_sum = {1'b0, cur_min} + 7'(SNOOZE_MIN);
        sn_hr  = cur_hr;
        sn_min = sn_sum[5:0];
        if (sn_sum >= 7'd60) begin
            sn_min = 6'(sn_sum - 7'd60);
            sn_hr  = (cur_hr == 5'd23) ? 5'd0 : cur_hr + 5'd1;
        end
    end
`endif

    assign any_btn   = btn_mode | btn_up | btn_set;
    assign in_edit   = (state == S_SEL) || (state == S_EDIT_HR) || (state == S_EDIT_MIN);
    assign timed_out = in_edit && !any_btn && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign strobe_on = LD_time | LD_alarm | STOP_al;

    assign edit_active = in_edit;
    assign busy        = (state == S_LOAD);

    always_comb begin
        edit_field = 2'd0;
        if (state == S_EDIT_HR)  edit_field = 2'd1;
        if (state == S_EDIT_MIN) edit_field = 2'd2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            kind      <= K_TIME;
            tgt_alarm <= 1'b0;
            work_hr   <= 5'd0;
            work_min  <= 6'd0;
            al_hr     <= 5'd0;
            al_min    <= 6'd0;
            ld_cnt    <= '0;
            to_cnt    <= '0;
            LD_time   <= 1'b0;
            LD_alarm  <= 1'b0;
            STOP_al   <= 1'b0;
            H_in1     <= 2'd0;
            H_in0     <= 4'd0;
            M_in1     <= 4'd0;
            M_in0     <= 4'd0;
        end else begin
            H_in1 <= hr_t;
            H_in0 <= hr_u;
            M_in1 <= {1'b0, mn_t};
            M_in0 <= mn_u;

            // Every entry into an edit state is caused by a button, so this also clears on entry.
            to_cnt <= (in_edit && !any_btn) ? to_cnt + 1'b1 : '0;

            case (state)
                S_IDLE: begin
                    if (btn_mode) begin
                        state     <= S_SEL;
                        tgt_alarm <= 1'b0;
                    end else if (btn_set && alarm) begin
                        state <= S_LOAD;
                        kind  <= K_STOP;
`ifdef IIITB_SNOOZE_EN
                    end else if (btn_up && alarm) begin
                        state    <= S_LOAD;
                        kind     <= K_SNOOZE;
                        work_hr  <= sn_hr;
                        work_min <= sn_min;
`endif
                    end
                end
                S_SEL: begin
                    if (timed_out) begin
                        state <= S_IDLE;
                    end else if (btn_mode) begin
                        state    <= S_EDIT_HR;
                        work_hr  <= tgt_alarm ? al_hr  : cur_hr;
                        work_min <= tgt_alarm ? al_min : cur_min;
                    end else if (btn_set) begin
                        state <= S_IDLE;
                    end else if (btn_up) begin
                        tgt_alarm <= ~tgt_alarm;
                    end
                end
                S_EDIT_HR: begin
                    if (timed_out) begin
                        state <= S_IDLE;
                    end else if (btn_mode) begin
                        state <= S_EDIT_MIN;
                    end else if (btn_set) begin
                        state <= S_LOAD;
                        kind  <= tgt_alarm ? K_ALARM : K_TIME;
                    end else if (btn_up) begin
                        work_hr <= hr_next;
                    end
                end
                S_EDIT_MIN: begin
                    if (timed_out) begin
                        state <= S_IDLE;
                    end else if (btn_mode) begin
                        state <= S_EDIT_HR;
                    end else if (btn_set) begin
                        state <= S_LOAD;
                        kind  <= tgt_alarm ? K_ALARM : K_TIME;
                    end else if (btn_up) begin
                        work_min <= min_next;
                    end
                end
                S_LOAD: begin
                    if (!strobe_on) begin
                        ld_cnt <= LW'(1);
                        case (kind)
                            K_TIME: LD_time <= 1'b1;
                            K_ALARM: begin
                                LD_alarm <= 1'b1;
                                al_hr    <= work_hr;
                                al_min   <= work_min;
                            end
                            default: STOP_al <= 1'b1;
                        endcase
                    end else if (ld_cnt == LW'(LD_HOLD)) begin
                        LD_time  <= 1'b0;
                        LD_alarm <= 1'b0;
                        STOP_al  <= 1'b0;
                        ld_cnt   <= '0;
`ifdef IIITB_SNOOZE_EN
                        // Snooze chains straight into an alarm load of the precomputed time.
                        if (kind == K_SNOOZE) kind  <= K_ALARM;
                        else                  state <= S_IDLE;
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        ld_cnt <= ld_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iiitb_clock_setctl.sv
// tb/tb_iiitb_clock_setctl.sv - directed vector bench for iiitb_clock_setctl
module tb_iiitb_clock_setctl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_set = 1'b0;
    logic       alarm = 1'b0;
    logic [1:0] cur_h1 = 2'd2;
    logic [3:0] cur_h0 = 4'd2;
    logic [3:0] cur_m1 = 4'd5;
    logic [3:0] cur_m0 = 4'd8;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       STOP_al;
    logic       edit_active;
    logic [1:0] edit_field;
    logic       tgt_alarm;
    logic       busy;

    int checks = 0;
    int errors = 0;

    iiitb_clock_setctl dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_set(btn_set), .alarm(alarm),
        .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al),
        .edit_active(edit_active), .edit_field(edit_field),
        .tgt_alarm(tgt_alarm), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic       u;
        logic       s;
        logic       al;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [7:0] ctl();
        return {LD_time, LD_alarm, STOP_al, edit_active, edit_field, tgt_alarm, busy};
    endfunction

    function automatic logic [13:0] digs();
        return {H_in1, H_in0, M_in1, M_in0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_dig(input string name, input int h1, input int h0, input int m1, input int m0);
        logic [13:0] e;
        e = {2'(h1), 4'(h0), 4'(m1), 4'(m0)};
        check(name, {18'd0, digs()}, {18'd0, e});
    endtask

    task automatic step(input logic m, input logic u, input logic s);
        btn_mode = m;
        btn_up   = u;
        btn_set  = s;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_set  = 1'b0;
    endtask

    task automatic press(input logic m, input logic u, input logic s, input int n);
        repeat (n) step(m, u, s);
    endtask

    // Starts on the first LOAD cycle; walks until busy drops, tallying strobe-high cycles.
    task automatic run_load(input logic poke, output int nt, output int na, output int ns,
                            output int nb, output int nd);
        logic [13:0] ref_d;
        logic        have;
        nt = 0; na = 0; ns = 0; nb = 0; nd = 0;
        have  = 1'b0;
        ref_d = '0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            nb++;
            if (LD_time)  nt++;
            if (LD_alarm) na++;
            if (STOP_al)  ns++;
            if (LD_time | LD_alarm | STOP_al) begin
                if (!have) begin
                    ref_d = digs();
                    have  = 1'b1;
                end else if (digs() !== ref_d) begin
                    nd++;
                end
            end
            step(poke, poke, poke);
        end
    endtask

    task automatic load_expect(input string name, input logic poke, input int et, input int ea,
                               input int es, input int eb);
        int nt, na, ns, nb, nd;
        run_load(poke, nt, na, ns, nb, nd);
        check({name, "_ld_time"}, nt, et);
        check({name, "_ld_alarm"}, na, ea);
        check({name, "_stop_al"}, ns, es);
        check({name, "_busy_len"}, nb, eb);
        check({name, "_dig_stable"}, nd, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, "idle"};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'b0000_0000, "set_no_alarm"};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0000, "up_idle"};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'b0001_0000, "mode_set_prio"};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'b0001_0010, "tgt_on"};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'b0001_0000, "tgt_off"};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'b0000_0000, "sel_cancel"};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'b0001_0000, "enter_sel"};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'b0001_0100, "enter_hr"};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'b0001_1000, "to_min"};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'b0001_0100, "to_hr"};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'b0001_1000, "mode_beats_all"};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'b0000_0001, "set_beats_up"};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {24'd0, ctl()}, 32'd0);
        check_dig("rst_dig", 0, 0, 0, 0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            alarm = tbl[i].al;
            step(tbl[i].m, tbl[i].u, tbl[i].s);
            check(tbl[i].name, {24'd0, ctl()}, {24'd0, tbl[i].exp});
        end
        alarm = 1'b0;
        load_expect("tbl_load", 1'b1, 20, 0, 0, 21);
        check("tbl_post_idle", {31'd0, edit_active}, 32'd0);
        check_dig("tbl_dig_2258", 2, 2, 5, 8);

        // Time set from 22:58: hour 22->1, minute 58->0.
        press(1, 0, 0, 2);
        press(0, 1, 0, 3);
        press(1, 0, 0, 1);
        press(0, 1, 0, 2);
        press(0, 0, 1, 1);
        check_dig("time_dig_0100", 0, 1, 0, 0);
        load_expect("time_set", 1'b1, 20, 0, 0, 21);
        check("time_post", {24'd0, ctl()}, 32'd0);

        // Alarm set to 07:30 from the reset shadow 00:00.
        press(1, 0, 0, 1);
        press(0, 1, 0, 1);
        press(1, 0, 0, 1);
        press(0, 1, 0, 7);
        press(1, 0, 0, 1);
        press(0, 1, 0, 30);
        press(0, 0, 1, 1);
        check_dig("alarm_dig_0730", 0, 7, 3, 0);
        load_expect("alarm_set", 1'b0, 0, 20, 0, 21);

        // Re-enter alarm edit, then let it time out with a restart at cycle 599.
        press(1, 0, 0, 1);
        press(0, 1, 0, 1);
        press(1, 0, 0, 1);
        step(0, 0, 0);
        check_dig("reenter_dig_0730", 0, 7, 3, 0);
        check("reenter_field", {30'd0, edit_field}, 32'd1);
        check("reenter_tgt", {31'd0, tgt_alarm}, 32'd1);
        press(0, 0, 0, 598);
        check("to_still_active_599", {31'd0, edit_active}, 32'd1);
        step(0, 1, 0);
        check("to_restart", {31'd0, edit_active}, 32'd1);
        press(0, 0, 0, 599);
        check("to_active_after_restart", {31'd0, edit_active}, 32'd1);
        step(0, 0, 0);
        check("to_idle", {24'd0, ctl()}, 32'h02);
        press(1, 0, 0, 1);
        press(0, 1, 0, 1);
        press(1, 0, 0, 1);
        step(0, 0, 0);
        check_dig("to_discard_0730", 0, 7, 3, 0);
        press(0, 0, 1, 1);
        load_expect("alarm_again", 1'b0, 0, 20, 0, 21);

        // Stop alarm, and the ignored stop with alarm low.
        alarm = 1'b1;
        step(0, 0, 1);
        check("stop_entry", {30'd0, busy, STOP_al}, 32'b10);
        load_expect("stop", 1'b0, 0, 0, 20, 21);
        alarm = 1'b0;
        step(0, 0, 1);
        press(0, 0, 0, 3);
        check("stop_no_alarm", {29'd0, busy, STOP_al, edit_active}, 32'd0);

        // Asynchronous reset in the middle of a STOP load.
        alarm = 1'b1;
        step(0, 0, 1);
        alarm = 1'b0;
        press(0, 0, 0, 5);
        check("mid_load_stop_high", {31'd0, STOP_al}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_ctl", {24'd0, ctl()}, 32'd0);
        check_dig("async_rst_dig", 0, 0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        press(0, 0, 0, 3);
        check("post_rst_ctl", {24'd0, ctl()}, 32'd0);
        press(1, 0, 0, 1);
        press(0, 1, 0, 1);
        press(1, 0, 0, 1);
        step(0, 0, 0);
        check_dig("post_rst_shadow", 0, 0, 0, 0);
        press(0, 0, 1, 1);
        load_expect("post_rst_alarm", 1'b0, 0, 20, 0, 21);

        // Snooze from 23:58 with the alarm ringing.
        cur_h1 = 2'd2;
        cur_h0 = 4'd3;
        cur_m1 = 4'd5;
        cur_m0 = 4'd8;
        alarm  = 1'b1;
        step(0, 1, 0);
        alarm  = 1'b0;
`ifdef IIITB_SNOOZE_EN
        check("snooze_entry", {30'd0, busy, STOP_al}, 32'b10);
        load_expect("snooze", 1'b0, 0, 20, 20, 42);
        check_dig("snooze_dig_0003", 0, 0, 0, 3);
        press(1, 0, 0, 1);
        press(0, 1, 0, 1);
        press(1, 0, 0, 1);
        step(0, 0, 0);
        check_dig("snooze_shadow", 0, 0, 0, 3);
        press(0, 0, 1, 1);
        load_expect("snooze_recommit", 1'b0, 0, 20, 0, 21);
`else
        begin
            int act_cnt;
            act_cnt = 0;
            for (int i = 0; i < 25; i++) begin
                if (busy | LD_time | LD_alarm | STOP_al | edit_active) act_cnt++;
                step(0, 0, 0);
            end
            check("no_snooze_activity", act_cnt, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
